fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch PC register and sequences instruction fetch for the pipelined core.
- Advances the PC, holds it on load-use hazards and on instruction-memory wait states, and applies taken-branch/jump redirects resolved in EX by pccalc.
- Generates the IF/ID and ID/EX flush/stall controls and the `stay` hold signal to pccalc.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  EX-stage branch/jump taken this cycle
- redirect_pc  in  32  redirect target from pccalc
- load_use_hazard  in  1  decode-stage load-use stall request
- imem_ready  in  1  instruction memory completes the current request this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= pc)
- pc  out  32  current fetch PC
- stay  out  1  PC not updated this cycle (to pccalc)
- stall_ifid  out  1  hold IF/ID register
- flush_ifid  out  1  squash IF/ID register
- flush_idex  out  1  squash ID/EX register
- redirect_cnt  out  CNT_W  saturating count of redirect cycles

Behaviour:
Reset (async, any state, including mid-wait):
- state=BOOT, pc=RESET_PC, pend_valid=0, redirect_cnt=0.
- Outputs: imem_req=0, stay=1, stall_ifid=0.
- flush_ifid and flush_idex are combinational; they are forced to 0 while rst=1.

States:
- BOOT: imem_req=0, stay=1. Moves unconditionally to RUN on the next clock.
- RUN: imem_req=1, imem_addr=pc. Priority: redirect > load_use_hazard > advance.
  - redirect_valid=1, imem_ready=1: pc<=redirect_pc with bits[1:0] forced to 0; stay=0.
  - redirect_valid=1, imem_ready=0: pend_pc<=redirect_pc (aligned), pend_valid<=1, go to MEM_WAIT; pc held, stay=1.
  - load_use_hazard=1 without redirect: pc held, stay=1, stall_ifid=1. Applies whether or not imem_ready is high; the returned instruction is re-fetched.
  - Otherwise, imem_ready=1: pc<=pc+4, stay=0.
  - Otherwise, imem_ready=0: go to MEM_WAIT, pc held, stay=1.
- MEM_WAIT: imem_req=1; imem_addr held stable at pc until imem_ready.
  - redirect_valid=1, imem_ready=0: capture pend_pc; the latest redirect wins.
  - imem_ready=1 with redirect_valid=1 that cycle: pc<=redirect_pc, pend_valid<=0.
  - imem_ready=1 with pend_valid=1 (no same-cycle redirect): pc<=pend_pc, pend_valid<=0, flush_ifid=1 to discard the stale returned instruction.
  - imem_ready=1 otherwise: same rules as RUN (hazard holds, else pc+4).
  - Any imem_ready=1 returns the block to RUN.

Flush rules:
- flush_ifid=flush_idex=1 combinationally in any cycle with redirect_valid=1 and state≠BOOT.
- stall_ifid is forced to 0 whenever flush_ifid=1.

Arithmetic and counter:
- pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- redirect_cnt increments by one per cycle with redirect_valid=1 and saturates at all-ones.

Latency:
- A redirect takes effect at pc one clock after redirect_valid when imem_ready=1, otherwise on the clock of the completing imem_ready.

Decomposition:
- Package (extend controls.sv): state enum {BOOT, RUN, MEM_WAIT}, PC_INC=4, and the alignment mask constant.
- One sub-module: sat_counter (CNT_W parameter, inc input, value output) for redirect_cnt.
- Everything else lives in fetch_sequencer.

Test Plan:
1. rst pulse, RESET_PC=0, imem_ready=1 held -> one BOOT cycle with imem_req=0, then imem_addr 0x0, 0x4, 0x8, 0xC on successive clocks.
2. At pc=0x10, redirect_valid=1 with redirect_pc=0xAC and imem_ready=1 -> same cycle flush_ifid=flush_idex=1; next clock pc=0xAC; redirect_cnt=1.
3. At pc=0x8, load_use_hazard=1 for one cycle -> stall_ifid=1, stay=1, pc remains 0x8; next clock 0xC.
4. At pc=0x20, imem_ready=0 for 3 cycles, redirect 0x100 in wait cycle 2 -> imem_addr stays 0x20 throughout; on imem_ready=1, flush_ifid=1; next clock pc=0x100.
5. Boundaries:
   - redirect and load_use_hazard in the same cycle -> stall_ifid=0, pc loads the redirect target.
   - pc=0xFFFFFFFC with imem_ready=1 -> pc becomes 0x0.
   - redirect_pc=0x103 -> pc becomes 0x100.
6. rst asserted in MEM_WAIT with pend_valid=1 -> immediately pc=RESET_PC, imem_req=0, pend cleared; after release, the sequence restarts as in scenario 1 with no flush.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared types and constants for the instruction fetch sequencer:
//   - fetch_state_e : sequencer FSM states
//   - PC_INC        : sequential fetch stride in bytes
//   - ALIGN_MASK    : clears bits [1:0] of a redirect target
//   - align_pc()    : applies ALIGN_MASK to an address
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Redirect targets are word aligned; low address bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter. Increments once per cycle with inc_i high and sticks
// at all-ones.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (clears the count)
//   inc_i   : increment request
//   value_o : current count (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: hold at all-ones once saturated.
  always_comb begin
    value_d = value_q;
    if (inc_i && (value_q != {CNT_W{1'b1}})) begin
      value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      value_d = value_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= {CNT_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the fetch PC and sequences instruction fetch: sequential advance,
// load-use hold, instruction-memory wait states and EX-stage redirects.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   redirect_valid_i    : EX-stage taken branch/jump this cycle
//   redirect_pc_i       : redirect target (low two bits ignored)
//   load_use_hazard_i   : decode load-use stall request
//   imem_ready_i        : instruction memory completes current request
//   imem_req_o          : fetch request valid
//   imem_addr_o, pc_o   : current fetch PC
//   stay_o              : PC not updated this cycle
//   stall_ifid_o        : hold IF/ID register
//   flush_ifid_o        : squash IF/ID register (combinational)
//   flush_idex_o        : squash ID/EX register (combinational)
//   redirect_cnt_o      : saturating count of redirect cycles
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             load_use_hazard_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic             stay_o,
  output logic             stall_ifid_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic         stall_s;
  logic         flush_pend_s;
  logic         flush_redirect_s;
  logic [31:0]  redirect_aligned_s;

  assign redirect_aligned_s = align_pc(redirect_pc_i);

  // Next-state, next-PC and per-cycle control decode.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    imem_req_o   = 1'b0;
    stay_o       = 1'b1;
    stall_s      = 1'b0;
    flush_pend_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        imem_req_o = 1'b1;
        if (redirect_valid_i) begin
          if (imem_ready_i) begin
            pc_d   = redirect_aligned_s;
            stay_o = 1'b0;
          end else begin
            // Park the target until the outstanding fetch completes.
            pend_pc_d    = redirect_aligned_s;
            pend_valid_d = 1'b1;
            state_d      = ST_MEM_WAIT;
          end
        end else if (load_use_hazard_i) begin
          // Returned instruction (if any) is dropped and re-fetched.
          stall_s = 1'b1;
        end else if (imem_ready_i) begin
          pc_d   = pc_q + PC_INC;
          stay_o = 1'b0;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        imem_req_o = 1'b1;
        if (!imem_ready_i) begin
          if (redirect_valid_i) begin
            pend_pc_d    = redirect_aligned_s;
            pend_valid_d = 1'b1;
          end else begin
            pend_valid_d = pend_valid_q;
          end
        end else begin
          state_d      = ST_RUN;
          pend_valid_d = 1'b0;
          if (redirect_valid_i) begin
            pc_d   = redirect_aligned_s;
            stay_o = 1'b0;
          end else if (pend_valid_q) begin
            // Instruction returned now belongs to the wrong path.
            pc_d         = pend_pc_q;
            stay_o       = 1'b0;
            flush_pend_s = 1'b1;
          end else if (load_use_hazard_i) begin
            stall_s = 1'b1;
          end else begin
            pc_d   = pc_q + PC_INC;
            stay_o = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign flush_redirect_s = redirect_valid_i && (state_q != ST_BOOT);
  assign flush_ifid_o     = !rst_i && (flush_redirect_s || flush_pend_s);
  assign flush_idex_o     = !rst_i && flush_redirect_s;
  assign stall_ifid_o     = stall_s && !flush_ifid_o;
  assign imem_addr_o      = pc_q;
  assign pc_o             = pc_q;

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0000_0000;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_redirect_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (redirect_valid_i),
    .value_o (redirect_cnt_o)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          load_use_hazard;
  logic          imem_ready;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   pc;
  logic          stay;
  logic          stall_ifid;
  logic          flush_ifid;
  logic          flush_idex;
  logic [CW-1:0] redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .redirect_valid_i  (redirect_valid),
    .redirect_pc_i     (redirect_pc),
    .load_use_hazard_i (load_use_hazard),
    .imem_ready_i      (imem_ready),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .pc_o              (pc),
    .stay_o            (stay),
    .stall_ifid_o      (stall_ifid),
    .flush_ifid_o      (flush_ifid),
    .flush_idex_o      (flush_idex),
    .redirect_cnt_o    (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    load_use_hazard = 1'b0; imem_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  // Reset, then advance with imem_ready high until pc reaches target.
  task automatic go_to(input logic [31:0] target);
    int n;
    do_reset();
    cycle();
    n = 0;
    while (pc !== target && n < 200) begin
      cycle();
      n++;
    end
    n_checks++;
    if (pc !== target) begin
      $display("FAIL go_to: pc=%h, required %h within 200 cycles", pc, target);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    load_use_hazard = 1'b1; imem_ready = 1'b1;
    cycle(); cycle();
    n_checks++; if (pc !== 32'h0) begin $display("FAIL rst_pc: got %h want 0", pc); n_fail++; end
    n_checks++; if (imem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", imem_req); n_fail++; end
    n_checks++; if (stay !== 1'b1) begin $display("FAIL rst_stay: got %b want 1", stay); n_fail++; end
    n_checks++; if (stall_ifid !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", stall_ifid); n_fail++; end
    n_checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
      $display("FAIL rst_flush: got %b%b want 00", flush_ifid, flush_idex); n_fail++; end
    n_checks++; if (redirect_cnt !== 4'd0) begin $display("FAIL rst_cnt: got %0d want 0", redirect_cnt); n_fail++; end
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp;
    do_reset();
    #1;
    n_checks++; if (imem_req !== 1'b0 || stay !== 1'b1) begin
      $display("FAIL boot_req: req=%b stay=%b want req=0 stay=1", imem_req, stay); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp = 32'(i * 4);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp) begin
        $display("FAIL boot_seq%0d: req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp); n_fail++; end
    end
  endtask

  task automatic test_redirect();
    go_to(32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'hAC;
    #1;
    n_checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || stay !== 1'b0) begin
      $display("FAIL redir_flush: fi=%b fe=%b stay=%b want 1 1 0", flush_ifid, flush_idex, stay); n_fail++; end
    cycle();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'hAC) begin $display("FAIL redir_pc: got %h want 000000ac", pc); n_fail++; end
    n_checks++; if (redirect_cnt !== 4'd1) begin $display("FAIL redir_cnt: got %0d want 1", redirect_cnt); n_fail++; end
    cycle();
    n_checks++; if (pc !== 32'hB0) begin $display("FAIL redir_next: got %h want 000000b0", pc); n_fail++; end
  endtask

  task automatic test_load_use();
    go_to(32'h8);
    load_use_hazard = 1'b1;
    #1;
    n_checks++; if (stall_ifid !== 1'b1 || stay !== 1'b1 || flush_ifid !== 1'b0) begin
      $display("FAIL lu_ctrl: stall=%b stay=%b flush=%b want 1 1 0", stall_ifid, stay, flush_ifid); n_fail++; end
    cycle();
    load_use_hazard = 1'b0;
    n_checks++; if (pc !== 32'h8) begin $display("FAIL lu_hold: got %h want 00000008", pc); n_fail++; end
    cycle();
    n_checks++; if (pc !== 32'hC) begin $display("FAIL lu_resume: got %h want 0000000c", pc); n_fail++; end
  endtask

  task automatic test_mem_wait();
    go_to(32'h20);
    // RUN cycle with memory not ready plus a redirect that gets superseded.
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    n_checks++; if (imem_addr !== 32'h20 || stay !== 1'b1 || flush_ifid !== 1'b1) begin
      $display("FAIL mw_c1: addr=%h stay=%b fi=%b want 20 1 1", imem_addr, stay, flush_ifid); n_fail++; end
    cycle();
    redirect_pc = 32'h100;
    #1;
    n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1 || flush_idex !== 1'b1) begin
      $display("FAIL mw_c2: addr=%h req=%b fe=%b want 20 1 1", imem_addr, imem_req, flush_idex); n_fail++; end
    cycle();
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h20 || flush_ifid !== 1'b0 || stay !== 1'b1) begin
      $display("FAIL mw_c3: addr=%h fi=%b stay=%b want 20 0 1", imem_addr, flush_ifid, stay); n_fail++; end
    cycle();
    imem_ready = 1'b1;
    #1;
    n_checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b0 || stay !== 1'b0 || imem_addr !== 32'h20) begin
      $display("FAIL mw_done: fi=%b fe=%b stay=%b addr=%h want 1 0 0 20", flush_ifid, flush_idex, stay, imem_addr); n_fail++; end
    cycle();
    n_checks++; if (pc !== 32'h100) begin $display("FAIL mw_pc: got %h want 00000100", pc); n_fail++; end
    n_checks++; if (redirect_cnt !== 4'd2) begin $display("FAIL mw_cnt: got %0d want 2", redirect_cnt); n_fail++; end
  endtask

  task automatic test_boundaries();
    go_to(32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40; load_use_hazard = 1'b1;
    #1;
    n_checks++; if (stall_ifid !== 1'b0 || flush_ifid !== 1'b1) begin
      $display("FAIL bnd_prio: stall=%b fi=%b want 0 1", stall_ifid, flush_ifid); n_fail++; end
    cycle();
    load_use_hazard = 1'b0;
    n_checks++; if (pc !== 32'h40) begin $display("FAIL bnd_prio_pc: got %h want 00000040", pc); n_fail++; end
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin $display("FAIL bnd_top: got %h want fffffffc", pc); n_fail++; end
    cycle();
    n_checks++; if (pc !== 32'h0) begin $display("FAIL bnd_wrap: got %h want 00000000", pc); n_fail++; end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'h100) begin $display("FAIL bnd_align: got %h want 00000100", pc); n_fail++; end
    n_checks++; if (redirect_cnt !== 4'd3) begin $display("FAIL bnd_cnt: got %0d want 3", redirect_cnt); n_fail++; end
  endtask

  task automatic test_saturate();
    do_reset();
    // Still in BOOT: a redirect must not flush.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    n_checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
      $display("FAIL boot_noflush: fi=%b fe=%b want 0 0", flush_ifid, flush_idex); n_fail++; end
    for (int i = 0; i < 20; i++) cycle();
    redirect_valid = 1'b0;
    n_checks++; if (redirect_cnt !== 4'hF) begin $display("FAIL sat_cnt: got %0d want 15", redirect_cnt); n_fail++; end
    n_checks++; if (pc !== 32'h40) begin $display("FAIL sat_pc: got %h want 00000040", pc); n_fail++; end
  endtask

  task automatic test_reset_mid_wait();
    go_to(32'h20);
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (pc !== 32'h0 || imem_req !== 1'b0 || stay !== 1'b1 || redirect_cnt !== 4'd0) begin
      $display("FAIL rmw_async: pc=%h req=%b stay=%b cnt=%0d want 0 0 1 0", pc, imem_req, stay, redirect_cnt); n_fail++; end
    imem_ready = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || flush_ifid !== 1'b0) begin
      $display("FAIL rmw_restart: addr=%h req=%b fi=%b want 0 1 0", imem_addr, imem_req, flush_ifid); n_fail++; end
    // A stale pending redirect would surface on this wait's completion.
    imem_ready = 1'b0;
    cycle();
    imem_ready = 1'b1;
    #1;
    n_checks++; if (flush_ifid !== 1'b0) begin $display("FAIL rmw_pend_flush: got %b want 0", flush_ifid); n_fail++; end
    cycle();
    n_checks++; if (pc !== 32'h4) begin $display("FAIL rmw_pend_pc: got %h want 00000004", pc); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_redirect();
    test_load_use();
    test_mem_wait();
    test_boundaries();
    test_saturate();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
